// File: rtl/complex_addsub_pipe.sv
// rtl/complex_addsub_pipe.sv - pipelined multi-lane fixed-point complex add/subtract
// Arithmetic is combinational ahead of stage 0; later stages only delay result, ovf and tag.
module complex_addsub_pipe #(
  parameter int NUM_LANES  = 2,
  parameter int WIDTH      = 16,
  parameter int PIPE_DEPTH = 3,
  parameter int SATURATE   = 1,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     in_valid_i,
  output logic                                     in_ready_o,
  input  logic                                     flush_i,
  input  logic [NUM_LANES-1:0][3:0][WIDTH-1:0]     operands_i,
  input  logic [1:0]                               op_i,
  input  logic [TAG_WIDTH-1:0]                     tag_i,
  output logic [NUM_LANES-1:0][1:0][WIDTH-1:0]     result_o,
  output logic [2*NUM_LANES-1:0]                   ovf_o,
  output logic [TAG_WIDTH-1:0]                     tag_o,
  output logic                                     out_valid_o,
  input  logic                                     out_ready_i,
  output logic                                     busy_o
);
  localparam int LAST = PIPE_DEPTH - 1;
  typedef logic [NUM_LANES-1:0][1:0][WIDTH-1:0] res_t;

  res_t                   res_d;
  logic [2*NUM_LANES-1:0] ovf_d;
  logic [WIDTH:0]         sum_re, sum_im;
  logic [PIPE_DEPTH-1:0]  ready;
  logic                   busy_any;

  logic                   valid_q [PIPE_DEPTH];
  res_t                   res_q   [PIPE_DEPTH];
  logic [2*NUM_LANES-1:0] ovf_q   [PIPE_DEPTH];
  logic [TAG_WIDTH-1:0]   tag_q   [PIPE_DEPTH];

  function automatic logic [WIDTH:0] addsub(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic             sub);
    logic [WIDTH:0] ae, be;
    ae = {a[WIDTH-1], a};
    be = {b[WIDTH-1], b};
    return sub ? (ae - be) : (ae + be);
  endfunction

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH:0] s);
    logic [WIDTH-1:0] v;
    v = s[WIDTH-1:0];
    if (SATURATE != 0 && (s[WIDTH] != s[WIDTH-1]))
      v = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return v;
  endfunction

  // op_i[1] rotates b by +/-j: b's components swap and re/im subtract senses follow the op bits
  always_comb begin
    res_d  = '0;
    ovf_d  = '0;
    sum_re = '0;
    sum_im = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      sum_re = addsub(operands_i[l][0], op_i[1] ? operands_i[l][3] : operands_i[l][2],
                      op_i[0] ^ op_i[1]);
      sum_im = addsub(operands_i[l][1], op_i[1] ? operands_i[l][2] : operands_i[l][3],
                      op_i[0]);
      res_d[l][0]    = clamp(sum_re);
      res_d[l][1]    = clamp(sum_im);
      ovf_d[2*l]     = sum_re[WIDTH] ^ sum_re[WIDTH-1];
      ovf_d[2*l + 1] = sum_im[WIDTH] ^ sum_im[WIDTH-1];
    end
  end

  // A stage is ready if it or any stage downstream has a hole, or the sink accepts.
  always_comb begin
    logic acc;
    acc   = out_ready_i;
    ready = '0;
    for (int s = LAST; s >= 0; s--) begin
      acc      = acc | !valid_q[s];
      ready[s] = acc;
    end
  end

  always_comb begin
    busy_any = 1'b0;
    for (int s = 0; s < PIPE_DEPTH; s++) busy_any = busy_any | valid_q[s];
  end

  for (genvar s = 0; s < PIPE_DEPTH; s++) begin : g_stage
    logic                   src_valid;
    res_t                   src_res;
    logic [2*NUM_LANES-1:0] src_ovf;
    logic [TAG_WIDTH-1:0]   src_tag;

    if (s == 0) begin : g_first
      assign src_valid = in_valid_i;
      assign src_res   = res_d;
      assign src_ovf   = ovf_d;
      assign src_tag   = tag_i;
    end else begin : g_next
      assign src_valid = valid_q[s-1];
      assign src_res   = res_q[s-1];
      assign src_ovf   = ovf_q[s-1];
      assign src_tag   = tag_q[s-1];
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        valid_q[s] <= 1'b0;
        res_q[s]   <= '0;
        ovf_q[s]   <= '0;
        tag_q[s]   <= '0;
      end else begin
        if (flush_i)       valid_q[s] <= 1'b0;
        else if (ready[s]) valid_q[s] <= src_valid;
        if (ready[s]) begin
          res_q[s] <= src_res;
          ovf_q[s] <= src_ovf;
          tag_q[s] <= src_tag;
        end
      end
    end
  end

  assign in_ready_o  = ready[0] & !flush_i & rst_ni;
  assign out_valid_o = rst_ni & valid_q[LAST];
  assign busy_o      = rst_ni & busy_any;
  assign result_o    = rst_ni ? res_q[LAST] : '0;
  assign ovf_o       = rst_ni ? ovf_q[LAST] : '0;
  assign tag_o       = rst_ni ? tag_q[LAST] : '0;

endmodule

// File: tb/tb_complex_addsub_pipe.sv
// tb/tb_complex_addsub_pipe.sv - directed bench for complex_addsub_pipe
// A saturating and a wrapping instance share stimulus; each has its own expected-beat queue.
module tb_complex_addsub_pipe;
  localparam int NL = 2;
  localparam int W  = 16;
  localparam int PD = 3;
  localparam int TW = 4;
  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_ADDJ = 2'b10, OP_SUBJ = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic out_ready = 1'b1;
  logic [1:0] op = 2'b00;
  logic [TW-1:0] tag = '0;
  logic [NL-1:0][3:0][W-1:0] operands = '0;

  logic in_ready, out_valid, busy;
  logic [NL-1:0][1:0][W-1:0] result;
  logic [2*NL-1:0] ovf;
  logic [TW-1:0] tag_out;

  logic in_ready_w, out_valid_w, busy_w;
  logic [NL-1:0][1:0][W-1:0] result_w;
  logic [2*NL-1:0] ovf_w;
  logic [TW-1:0] tag_out_w;

  always #5 clk = ~clk;

  complex_addsub_pipe #(.NUM_LANES(NL), .WIDTH(W), .PIPE_DEPTH(PD), .SATURATE(1), .TAG_WIDTH(TW)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready), .flush_i(flush),
    .operands_i(operands), .op_i(op), .tag_i(tag), .result_o(result), .ovf_o(ovf), .tag_o(tag_out),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy));

  complex_addsub_pipe #(.NUM_LANES(NL), .WIDTH(W), .PIPE_DEPTH(PD), .SATURATE(0), .TAG_WIDTH(TW)) u_wrap (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_w), .flush_i(flush),
    .operands_i(operands), .op_i(op), .tag_i(tag), .result_o(result_w), .ovf_o(ovf_w), .tag_o(tag_out_w),
    .out_valid_o(out_valid_w), .out_ready_i(out_ready), .busy_o(busy_w));

  int checks = 0;
  int errors = 0;
  int outs = 0;
  int cyc = 0;
  logic [79:0] exp_q[$];
  logic [79:0] exp_w_q[$];
  logic [79:0] obs, obs_w;

  assign obs   = {8'h00, ovf, tag_out, result[0][0], result[0][1], result[1][0], result[1][1]};
  assign obs_w = {8'h00, ovf_w, tag_out_w, result_w[0][0], result_w[0][1], result_w[1][0], result_w[1][1]};

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      outs++;
      check("sat_out_expected", 80'(exp_q.size() != 0), 80'(1));
      if (exp_q.size() != 0) check("sat_beat", obs, exp_q.pop_front());
    end
    if (rst_n && out_valid_w && out_ready) begin
      check("wrap_out_expected", 80'(exp_w_q.size() != 0), 80'(1));
      if (exp_w_q.size() != 0) check("wrap_beat", obs_w, exp_w_q.pop_front());
    end
  end

  // Lane 1 carries a with b=0, so its result is a under every op.
  task automatic send(input logic [W-1:0] ar, input logic [W-1:0] ai, input logic [W-1:0] br,
                      input logic [W-1:0] bi, input logic [1:0] o, input logic [TW-1:0] t,
                      input logic [W-1:0] er, input logic [W-1:0] ei, input logic [W-1:0] wr,
                      input logic [W-1:0] wi, input logic [1:0] eov);
    logic acc;
    int n;
    exp_q.push_back({8'h00, 2'b00, eov, t, er, ei, ar, ai});
    exp_w_q.push_back({8'h00, 2'b00, eov, t, wr, wi, ar, ai});
    operands[0] = {bi, br, ai, ar};
    operands[1] = {16'h0000, 16'h0000, ai, ar};
    op = o;
    tag = t;
    in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("accept_timeout", 80'(0), 80'(1));
    in_valid = 1'b0;
  endtask

  task automatic send_lat(input logic [W-1:0] ar, input logic [W-1:0] ai, input logic [W-1:0] br,
                          input logic [W-1:0] bi, input logic [1:0] o, input logic [TW-1:0] t,
                          input logic [W-1:0] er, input logic [W-1:0] ei);
    int n;
    send(ar, ai, br, bi, o, t, er, ei, er, ei, 2'b00);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check("latency", 80'(n), 80'(PD));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_sat", 80'(exp_q.size()), 80'(0));
    check("drain_wrap", 80'(exp_w_q.size()), 80'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0, o0;
    // Reset held with a valid input offered.
    in_valid = 1'b1;
    operands[0] = {16'h0001, 16'h0002, 16'h0003, 16'h0004};
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", 80'(in_ready), 80'(0));
      check("rst_out_valid", 80'(out_valid), 80'(0));
      check("rst_busy", 80'(busy), 80'(0));
      check("rst_result", 80'(result), 80'(0));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 80'(in_ready), 80'(1));
    check("idle_busy", 80'(busy), 80'(0));
    @(posedge clk);
    #1;

    send_lat(16'h0700, 16'h0200, 16'h0100, 16'h0200, OP_ADD, 4'd5, 16'h0800, 16'h0400);
    drain();

    c0 = cyc;
    send(16'd10, 16'd20, 16'd3, 16'd4, OP_ADDJ, 4'd1, 16'd6, 16'd23, 16'd6, 16'd23, 2'b00);
    send(16'd10, 16'd20, 16'd3, 16'd4, OP_SUBJ, 4'd2, 16'd14, 16'd17, 16'd14, 16'd17, 2'b00);
    send(16'd10, 16'd20, 16'd3, 16'd4, OP_SUB, 4'd3, 16'd7, 16'd16, 16'd7, 16'd16, 2'b00);
    check("throughput", 80'(cyc - c0), 80'(3));
    drain();

    send(16'h7FFF, 16'h0000, 16'h0001, 16'h0000, OP_ADD, 4'd6, 16'h7FFF, 16'h0000, 16'h8000, 16'h0000, 2'b01);
    send(16'h8000, 16'h0000, 16'h0001, 16'h0000, OP_SUB, 4'd7, 16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 2'b01);
    send(16'h0000, 16'h7FFF, 16'h0001, 16'h0000, OP_ADDJ, 4'd8, 16'h0000, 16'h7FFF, 16'h0000, 16'h8000, 2'b10);
    send(16'h0000, 16'h8000, 16'h0001, 16'h0000, OP_SUBJ, 4'd9, 16'h0000, 16'h8000, 16'h0000, 16'h7FFF, 2'b10);
    send(16'h7FFE, 16'h8001, 16'h0001, 16'h0001, OP_SUB, 4'd10, 16'h7FFD, 16'h8000, 16'h7FFD, 16'h8000, 2'b00);
    drain();

    o0 = outs;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(16'(i), 16'(100 + i), 16'd1000, 16'd2000, OP_ADD, 4'(i),
               16'(1000 + i), 16'(2100 + i), 16'(1000 + i), 16'(2100 + i), 2'b00);
      end
      begin
        logic [79:0] held;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_two_held_ready", 80'(in_ready), 80'(1));
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_full_ready", 80'(in_ready), 80'(0));
        check("bp_out_valid", 80'(out_valid), 80'(1));
        check("bp_head_tag", 80'(tag_out), 80'(0));
        held = obs;
        @(posedge clk);
        @(negedge clk);
        check("bp_hold_stable", obs, held);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_beat_count", 80'(outs - o0), 80'(8));

    send(16'd1, 16'd2, 16'd3, 16'd4, OP_ADD, 4'd11, 16'd4, 16'd6, 16'd4, 16'd6, 2'b00);
    send(16'd1, 16'd2, 16'd3, 16'd4, OP_ADD, 4'd12, 16'd4, 16'd6, 16'd4, 16'd6, 2'b00);
    send(16'd1, 16'd2, 16'd3, 16'd4, OP_ADD, 4'd13, 16'd4, 16'd6, 16'd4, 16'd6, 2'b00);
    flush = 1'b1;
    in_valid = 1'b1;
    tag = 4'd14;
    @(negedge clk);
    check("flush_in_ready", 80'(in_ready), 80'(0));
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_discards_two", 80'(exp_q.size()), 80'(2));
    exp_q.delete();
    exp_w_q.delete();
    @(negedge clk);
    check("flush_out_valid", 80'(out_valid), 80'(0));
    check("flush_busy", 80'(busy), 80'(0));
    @(posedge clk);
    #1;
    send_lat(16'd10, 16'd20, 16'd3, 16'd4, OP_ADDJ, 4'd15, 16'd6, 16'd23);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
